// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake and operand/result bus for the bit-serial subtractor.
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] D;
  logic             Bout;

  // Requester side: issues operands, observes status and result.
  modport master (
    output start, A, B,
    input  busy, done, D, Bout
  );

  // Subtractor side.
  modport slave (
    input  start, A, B,
    output busy, done, D, Bout
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: D = A - B, one bit per clock, LSB first.
// A single full-subtractor cell plus a borrow flip-flop is iterated WIDTH times.
module serial_subtractor #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_subtractor_if.slave   bus
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_d;
  logic             r_borrow;
  logic             r_bout;
  logic             r_done;
  logic [CW-1:0]    r_cnt;

  logic             w_a;
  logic             w_b;
  logic             w_d;
  logic             w_bnext;
  logic             w_last;

  // Full-subtractor cell on the current operand LSBs and the stored borrow.
  assign w_a     = r_a[0];
  assign w_b     = r_b[0];
  assign w_d     = w_a ^ w_b ^ r_borrow;
  assign w_bnext = (~w_a & w_b) | (~(w_a ^ w_b) & r_borrow);
  assign w_last  = (r_cnt == CW'(WIDTH - 1));

  // Control FSM and datapath; D/Bout hold the last result until the next completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_d      <= '0;
      r_borrow <= 1'b0;
      r_bout   <= 1'b0;
      r_done   <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state  <= S_RUN;
            r_a      <= bus.A;
            r_b      <= bus.B;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
          end
        end
        S_RUN: begin
          r_res    <= {w_d, r_res[WIDTH-1:1]};
          r_a      <= r_a >> 1;
          r_b      <= r_b >> 1;
          r_borrow <= w_bnext;
          r_cnt    <= r_cnt + CW'(1);
          if (w_last) begin
            r_state <= S_DONE;
            r_d     <= {w_d, r_res[WIDTH-1:1]};
            r_bout  <= w_bnext;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = (r_state != S_IDLE);
  assign bus.done = r_done;
  assign bus.D    = r_d;
  assign bus.Bout = r_bout;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: WIDTH=4 vector table and corner sequences,
// plus a WIDTH=8 instance checked against (A-B) mod 256 and A<B.
module tb_serial_subtractor;

  logic clk;
  logic rst;

  int n_total;
  int n_pass;

  serial_subtractor_if #(.WIDTH(4)) bus4 ();
  serial_subtractor_if #(.WIDTH(8)) bus8 ();

  serial_subtractor #(.WIDTH(4)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4.slave)
  );

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] d;
    logic       bo;
    string      name;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // Full WIDTH=4 operation with latency, busy-length and pulse-width checks.
  task automatic run_op4(input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] ed, input logic eb, input string nm);
    int edges;
    int busy_cnt;
    @(negedge clk);
    bus4.A = a;
    bus4.B = b;
    bus4.start = 1'b1;
    @(posedge clk); #1;
    bus4.start = 1'b0;
    bus4.A = ~a;
    bus4.B = ~b;
    edges = 1;
    busy_cnt = bus4.busy ? 1 : 0;
    for (int k = 0; k < 20 && !bus4.done; k++) begin
      @(posedge clk); #1;
      edges++;
      if (bus4.busy) busy_cnt++;
    end
    chk($sformatf("%s latency", nm), 32'(edges), 32'd5);
    chk($sformatf("%s D", nm), 32'(bus4.D), 32'(ed));
    chk($sformatf("%s Bout", nm), 32'(bus4.Bout), 32'(eb));
    @(posedge clk); #1;
    chk($sformatf("%s done/busy fall", nm), {30'd0, bus4.done, bus4.busy}, 32'd0);
    chk($sformatf("%s busy cycles", nm), 32'(busy_cnt), 32'd5);
  endtask

  // WIDTH=8 operation checked against the arithmetic reference.
  task automatic run_op8(input logic [7:0] a, input logic [7:0] b);
    int edges;
    logic [7:0] ed;
    logic       eb;
    ed = a - b;
    eb = (a < b);
    @(negedge clk);
    bus8.A = a;
    bus8.B = b;
    bus8.start = 1'b1;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    bus8.A = $urandom_range(0, 255);
    bus8.B = $urandom_range(0, 255);
    edges = 1;
    for (int k = 0; k < 30 && !bus8.done; k++) begin
      @(posedge clk); #1;
      edges++;
    end
    chk($sformatf("w8 %0d-%0d {lat,Bout,D}", a, b),
        {16'(edges), 7'd0, bus8.Bout, bus8.D}, {16'd9, 7'd0, eb, ed});
    @(posedge clk); #1;
  endtask

  initial begin
    int ndone;
    int first_t;
    int second_t;
    int waited;

    n_total = 0;
    n_pass  = 0;

    vecs[0] = '{4'h9, 4'h3, 4'h6, 1'b0, "9-3"};
    vecs[1] = '{4'h3, 4'h9, 4'hA, 1'b1, "3-9"};
    vecs[2] = '{4'h0, 4'h1, 4'hF, 1'b1, "0-1"};
    vecs[3] = '{4'hF, 4'hF, 4'h0, 1'b0, "F-F"};
    vecs[4] = '{4'h0, 4'h0, 4'h0, 1'b0, "0-0"};
    vecs[5] = '{4'h8, 4'h7, 4'h1, 1'b0, "8-7"};
    vecs[6] = '{4'h7, 4'h8, 4'hF, 1'b1, "7-8"};
    vecs[7] = '{4'h5, 4'h0, 4'h5, 1'b0, "5-0"};
    vecs[8] = '{4'h0, 4'hF, 4'h1, 1'b1, "0-F"};
    vecs[9] = '{4'hF, 4'h0, 4'hF, 1'b0, "F-0"};

    rst = 1'b1;
    bus4.start = 1'b0; bus4.A = '0; bus4.B = '0;
    bus8.start = 1'b0; bus8.A = '0; bus8.B = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset w4 {busy,done,Bout,D}", {25'd0, bus4.busy, bus4.done, bus4.Bout, bus4.D}, 32'd0);
    chk("reset w8 {busy,done,Bout,D}", {21'd0, bus8.busy, bus8.done, bus8.Bout, bus8.D}, 32'd0);
    rst = 1'b0;

    // Table-driven WIDTH=4 vectors.
    for (int i = 0; i < 10; i++)
      run_op4(vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].bo, vecs[i].name);

    // start held high: restarts only from IDLE, one done every 6 cycles.
    @(negedge clk);
    bus4.A = 4'h9; bus4.B = 4'h3; bus4.start = 1'b1;
    ndone = 0; first_t = -1; second_t = -1;
    for (int e = 0; e < 20; e++) begin
      @(posedge clk); #1;
      if (bus4.done) begin
        ndone++;
        if (first_t < 0) first_t = e;
        else if (second_t < 0) second_t = e;
      end
    end
    bus4.start = 1'b0;
    chk("held start done count", 32'(ndone), 32'd3);
    chk("held start first done", 32'(first_t), 32'd4);
    chk("held start period", 32'(second_t - first_t), 32'd6);
    chk("held start D", 32'(bus4.D), 32'h6);
    waited = 0;
    while (bus4.busy && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    chk("held start drains to idle", 32'(bus4.busy), 32'd0);

    // start pulsed mid-RUN with other operands is ignored.
    @(negedge clk);
    bus4.A = 4'h9; bus4.B = 4'h3; bus4.start = 1'b1;
    @(posedge clk); #1;
    bus4.start = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    bus4.A = 4'h1; bus4.B = 4'hE; bus4.start = 1'b1;
    @(posedge clk); #1;
    bus4.start = 1'b0;
    for (int k = 0; k < 20 && !bus4.done; k++) begin
      @(posedge clk); #1;
    end
    chk("mid-run start {done,Bout,D}", {26'd0, bus4.done, bus4.Bout, bus4.D}, {26'd0, 1'b1, 1'b0, 4'h6});
    repeat (2) @(posedge clk);
    #1;
    chk("mid-run start no restart", 32'(bus4.busy), 32'd0);

    // D/Bout hold the previous result while a new op is in flight.
    @(negedge clk);
    bus4.A = 4'h2; bus4.B = 4'h1; bus4.start = 1'b1;
    @(posedge clk); #1;
    bus4.start = 1'b0;
    @(posedge clk); #1;
    chk("hold old D in RUN", {27'd0, bus4.busy, bus4.D}, {27'd0, 1'b1, 4'h6});
    for (int k = 0; k < 20 && !bus4.done; k++) begin
      @(posedge clk); #1;
    end
    chk("new result D", {27'd0, bus4.done, bus4.D}, {27'd0, 1'b1, 4'h1});
    @(posedge clk); #1;

    // Reset during RUN aborts the op and clears outputs; no done follows.
    @(negedge clk);
    bus4.A = 4'h3; bus4.B = 4'h9; bus4.start = 1'b1;
    @(posedge clk); #1;
    bus4.start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("reset mid-run {busy,done,Bout,D}", {25'd0, bus4.busy, bus4.done, bus4.Bout, bus4.D}, 32'd0);
    ndone = 0;
    for (int e = 0; e < 10; e++) begin
      @(posedge clk); #1;
      if (bus4.done || bus4.busy) ndone++;
    end
    chk("reset mid-run no done", 32'(ndone), 32'd0);

    // WIDTH=8: boundary pairs then a random sample.
    run_op8(8'd0,   8'd0);
    run_op8(8'd0,   8'd255);
    run_op8(8'd255, 8'd0);
    run_op8(8'd255, 8'd255);
    run_op8(8'd128, 8'd127);
    run_op8(8'd127, 8'd128);
    run_op8(8'd100, 8'd200);
    run_op8(8'd200, 8'd100);
    for (int i = 0; i < 200; i++)
      run_op8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
